// File: rtl/load_align_unit_pkg.sv
// Shared definitions for the load alignment unit: load select codes, the
// internal load-kind decode, access-size lookup and the controller states.
package load_pkg;

    localparam logic [5:0] SEL_LB  = 6'b001011;
    localparam logic [5:0] SEL_LH  = 6'b001100;
    localparam logic [5:0] SEL_LW  = 6'b001101;
    localparam logic [5:0] SEL_LBU = 6'b001110;
    localparam logic [5:0] SEL_LHU = 6'b001111;
    localparam logic [5:0] SEL_LD  = 6'b010000;
    localparam logic [5:0] SEL_LWU = 6'b010001;

    // Decoded load flavour; PASS returns the aligned beat untouched.
    typedef enum logic [2:0] {
        KIND_B    = 3'd0,
        KIND_BU   = 3'd1,
        KIND_H    = 3'd2,
        KIND_HU   = 3'd3,
        KIND_W    = 3'd4,
        KIND_WU   = 3'd5,
        KIND_D    = 3'd6,
        KIND_PASS = 3'd7
    } kind_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    // LD and LWU only exist on a 64-bit datapath; otherwise they fall to PASS.
    function automatic kind_t decode_kind(input logic [5:0] sel, input int xlen);
        kind_t k;
        k = KIND_PASS;
        case (sel)
            SEL_LB:  k = KIND_B;
            SEL_LH:  k = KIND_H;
            SEL_LW:  k = KIND_W;
            SEL_LBU: k = KIND_BU;
            SEL_LHU: k = KIND_HU;
            SEL_LWU: k = (xlen == 64) ? KIND_WU : KIND_PASS;
            SEL_LD:  k = (xlen == 64) ? KIND_D : KIND_PASS;
            default: k = KIND_PASS;
        endcase
        return k;
    endfunction

    // Access size in bytes; PASS covers a whole beat.
    function automatic logic [4:0] kind_size(input kind_t k, input int xlen);
        logic [4:0] sz;
        case (k)
            KIND_B, KIND_BU: sz = 5'd1;
            KIND_H, KIND_HU: sz = 5'd2;
            KIND_W, KIND_WU: sz = 5'd4;
            KIND_D:          sz = 5'd8;
            default:         sz = 5'(xlen / 8);
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// Bundle of the request, memory and writeback handshakes of the load unit.
// slave is the unit's view, master is the surrounding pipeline/memory view.
interface load_align_unit_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            req_valid;
    logic            req_ready;
    logic [5:0]      req_sel;
    logic [XLEN-1:0] req_addr;
    logic [RD_W-1:0] req_rd;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_resp_data;

    logic            wb_valid;
    logic            wb_ready;
    logic [XLEN-1:0] wb_data;
    logic [RD_W-1:0] wb_rd;
    logic            wb_fault;

    modport slave (
        input  req_valid, req_sel, req_addr, req_rd,
        output req_ready,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output wb_valid, wb_data, wb_rd, wb_fault,
        input  wb_ready
    );

    modport master (
        output req_valid, req_sel, req_addr, req_rd,
        input  req_ready,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  wb_valid, wb_data, wb_rd, wb_fault,
        output wb_ready
    );
endinterface

// File: rtl/load_align_unit_extract.sv
// Combinational load extractor: shifts the {high,low} beat pair down to the
// addressed byte and sign/zero extends it. Also usable directly at the WB mux.
module load_extract
    import load_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [5:0]                 sel,
    input  logic [$clog2(XLEN/8)-1:0]  off,
    input  logic [XLEN-1:0]            low,
    input  logic [XLEN-1:0]            high,
    output logic [XLEN-1:0]            data
);
    localparam int SH_W = $clog2(XLEN / 8) + 3;

    kind_t             kind_s;
    logic [SH_W-1:0]   shift_s;
    logic [XLEN-1:0]   window_s;
    logic signed [7:0] b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] w_s;

    // Align the addressed element to bit 0 and apply the extension rule.
    always_comb begin
        kind_s   = decode_kind(sel, XLEN);
        shift_s  = {off, 3'b000};
        window_s = XLEN'({high, low} >> shift_s);
        b_s      = window_s[7:0];
        h_s      = window_s[15:0];
        w_s      = window_s[31:0];
        case (kind_s)
            KIND_B:  data = XLEN'(b_s);
            KIND_BU: data = XLEN'(window_s[7:0]);
            KIND_H:  data = XLEN'(h_s);
            KIND_HU: data = XLEN'(window_s[15:0]);
            KIND_W:  data = XLEN'(w_s);
            KIND_WU: data = XLEN'(window_s[31:0]);
            KIND_D:  data = window_s;
            default: data = low;
        endcase
    end
endmodule

// File: rtl/load_align_unit.sv
// Load alignment unit: accepts one load, fetches one or two aligned beats,
// extracts and extends the addressed value and hands it to writeback.
module load_align_unit
    import load_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int SPLIT_EN = 1,
    parameter int RD_W     = 5
) (
    input  logic              clk,
    input  logic              reset,
    load_align_unit_if.slave  bus
);
    localparam int   BYTES         = XLEN / 8;
    localparam int   OFF_W         = $clog2(BYTES);
    localparam logic SPLIT_ALLOWED = (SPLIT_EN != 0);

    state_t            state_r;
    state_t            next_state_s;

    logic [5:0]        sel_r;
    logic [OFF_W-1:0]  off_r;
    logic [RD_W-1:0]   rd_r;
    logic              split_r;
    logic [XLEN-1:0]   low_r;

    logic              req_ready_r;
    logic              mem_req_valid_r;
    logic [XLEN-1:0]   mem_req_addr_r;
    logic              wb_valid_r;
    logic [XLEN-1:0]   wb_data_r;
    logic [RD_W-1:0]   wb_rd_r;
    logic              wb_fault_r;

    kind_t             req_kind_s;
    logic [4:0]        req_size_s;
    logic [OFF_W-1:0]  req_off_s;
    logic              req_split_s;
    logic              req_fault_s;
    logic              accept_s;
    logic [XLEN-1:0]   beat0_s;
    logic [XLEN-1:0]   ext_low_s;
    logic [XLEN-1:0]   ext_high_s;
    logic [XLEN-1:0]   ext_data_s;

    assign bus.req_ready     = req_ready_r;
    assign bus.mem_req_valid = mem_req_valid_r;
    assign bus.mem_req_addr  = mem_req_addr_r;
    assign bus.wb_valid      = wb_valid_r;
    assign bus.wb_data       = wb_data_r;
    assign bus.wb_rd         = wb_rd_r;
    assign bus.wb_fault      = wb_fault_r;

    // Decode the incoming request: offset, size, beat-crossing and fault.
    always_comb begin
        req_kind_s = decode_kind(bus.req_sel, XLEN);
        req_size_s = kind_size(req_kind_s, XLEN);
        if (req_kind_s == KIND_PASS) begin
            req_off_s = {OFF_W{1'b0}};
        end else begin
            req_off_s = bus.req_addr[OFF_W-1:0];
        end
        req_split_s = ((5'(req_off_s) + req_size_s) > 5'(BYTES));
        req_fault_s = req_split_s && !SPLIT_ALLOWED;
        accept_s    = (state_r == S_IDLE) && bus.req_valid;
        beat0_s     = {bus.req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    end

    // Feed the extractor with the beat arriving this cycle so the result can
    // be registered on the same edge that completes the last fetch.
    always_comb begin
        if (state_r == S_WAIT0) begin
            ext_low_s  = bus.mem_resp_data;
            ext_high_s = {XLEN{1'b0}};
        end else if (state_r == S_WAIT1) begin
            ext_low_s  = low_r;
            ext_high_s = bus.mem_resp_data;
        end else begin
            ext_low_s  = low_r;
            ext_high_s = {XLEN{1'b0}};
        end
    end

    load_extract #(.XLEN(XLEN)) u_extract (
        .sel  (sel_r),
        .off  (off_r),
        .low  (ext_low_s),
        .high (ext_high_s),
        .data (ext_data_s)
    );

    // Controller next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.req_valid) begin
                    next_state_s = req_fault_s ? S_RESP : S_REQ0;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_REQ0: begin
                if (bus.mem_req_ready) next_state_s = S_WAIT0;
                else                   next_state_s = S_REQ0;
            end
            S_WAIT0: begin
                if (bus.mem_resp_valid) next_state_s = split_r ? S_REQ1 : S_RESP;
                else                    next_state_s = S_WAIT0;
            end
            S_REQ1: begin
                if (bus.mem_req_ready) next_state_s = S_WAIT1;
                else                   next_state_s = S_REQ1;
            end
            S_WAIT1: begin
                if (bus.mem_resp_valid) next_state_s = S_RESP;
                else                    next_state_s = S_WAIT1;
            end
            S_RESP: begin
                if (bus.wb_ready) next_state_s = S_IDLE;
                else              next_state_s = S_RESP;
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= S_IDLE;
        else       state_r <= next_state_s;
    end

    // Registered handshake outputs, request context and result datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready_r     <= 1'b1;
            mem_req_valid_r <= 1'b0;
            mem_req_addr_r  <= {XLEN{1'b0}};
            wb_valid_r      <= 1'b0;
            wb_data_r       <= {XLEN{1'b0}};
            wb_rd_r         <= {RD_W{1'b0}};
            wb_fault_r      <= 1'b0;
            sel_r           <= 6'd0;
            off_r           <= {OFF_W{1'b0}};
            rd_r            <= {RD_W{1'b0}};
            split_r         <= 1'b0;
            low_r           <= {XLEN{1'b0}};
        end else begin
            req_ready_r     <= (next_state_s == S_IDLE);
            mem_req_valid_r <= (next_state_s == S_REQ0) || (next_state_s == S_REQ1);
            wb_valid_r      <= (next_state_s == S_RESP);
            if (accept_s) begin
                sel_r   <= bus.req_sel;
                off_r   <= req_off_s;
                rd_r    <= bus.req_rd;
                split_r <= req_split_s;
                if (req_fault_s) begin
                    wb_fault_r <= 1'b1;
                    wb_data_r  <= {XLEN{1'b0}};
                    wb_rd_r    <= bus.req_rd;
                end else begin
                    wb_fault_r     <= 1'b0;
                    mem_req_addr_r <= beat0_s;
                end
            end else if ((state_r == S_WAIT0) && bus.mem_resp_valid) begin
                low_r <= bus.mem_resp_data;
                if (split_r) begin
                    mem_req_addr_r <= mem_req_addr_r + XLEN'(BYTES);
                end else begin
                    wb_data_r <= ext_data_s;
                    wb_rd_r   <= rd_r;
                end
            end else if ((state_r == S_WAIT1) && bus.mem_resp_valid) begin
                wb_data_r <= ext_data_s;
                wb_rd_r   <= rd_r;
            end
        end
    end
endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: a 32-bit splitting unit, a 32-bit
// faulting unit and a 64-bit unit share one set of stimulus signals, routed
// to the unit picked by dut_sel.
module tb_load_align_unit;
    import load_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req_valid;
    logic [5:0]  req_sel;
    logic [63:0] req_addr;
    logic [4:0]  req_rd;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        wb_ready;
    int          dut_sel;

    load_align_unit_if #(.XLEN(32), .RD_W(5)) if_a ();
    load_align_unit_if #(.XLEN(32), .RD_W(5)) if_b ();
    load_align_unit_if #(.XLEN(64), .RD_W(5)) if_c ();

    load_align_unit #(.XLEN(32), .SPLIT_EN(1), .RD_W(5)) u_split32 (.clk(clk), .reset(reset), .bus(if_a));
    load_align_unit #(.XLEN(32), .SPLIT_EN(0), .RD_W(5)) u_fault32 (.clk(clk), .reset(reset), .bus(if_b));
    load_align_unit #(.XLEN(64), .SPLIT_EN(1), .RD_W(5)) u_split64 (.clk(clk), .reset(reset), .bus(if_c));

    assign if_a.req_valid      = (dut_sel == 0) && req_valid;
    assign if_a.req_sel        = req_sel;
    assign if_a.req_addr       = req_addr[31:0];
    assign if_a.req_rd         = req_rd;
    assign if_a.mem_req_ready  = mem_req_ready;
    assign if_a.mem_resp_valid = (dut_sel == 0) && mem_resp_valid;
    assign if_a.mem_resp_data  = mem_resp_data[31:0];
    assign if_a.wb_ready       = (dut_sel == 0) && wb_ready;

    assign if_b.req_valid      = (dut_sel == 1) && req_valid;
    assign if_b.req_sel        = req_sel;
    assign if_b.req_addr       = req_addr[31:0];
    assign if_b.req_rd         = req_rd;
    assign if_b.mem_req_ready  = mem_req_ready;
    assign if_b.mem_resp_valid = (dut_sel == 1) && mem_resp_valid;
    assign if_b.mem_resp_data  = mem_resp_data[31:0];
    assign if_b.wb_ready       = (dut_sel == 1) && wb_ready;

    assign if_c.req_valid      = (dut_sel == 2) && req_valid;
    assign if_c.req_sel        = req_sel;
    assign if_c.req_addr       = req_addr;
    assign if_c.req_rd         = req_rd;
    assign if_c.mem_req_ready  = mem_req_ready;
    assign if_c.mem_resp_valid = (dut_sel == 2) && mem_resp_valid;
    assign if_c.mem_resp_data  = mem_resp_data;
    assign if_c.wb_ready       = (dut_sel == 2) && wb_ready;

    logic        o_req_ready, o_mem_req_valid, o_wb_valid, o_wb_fault;
    logic [63:0] o_mem_req_addr, o_wb_data;
    logic [4:0]  o_wb_rd;

    // Route the selected unit's outputs to a common 64-bit observation set.
    always_comb begin
        if (dut_sel == 0) begin
            o_req_ready = if_a.req_ready; o_mem_req_valid = if_a.mem_req_valid;
            o_mem_req_addr = 64'(if_a.mem_req_addr); o_wb_valid = if_a.wb_valid;
            o_wb_data = 64'(if_a.wb_data); o_wb_rd = if_a.wb_rd; o_wb_fault = if_a.wb_fault;
        end else if (dut_sel == 1) begin
            o_req_ready = if_b.req_ready; o_mem_req_valid = if_b.mem_req_valid;
            o_mem_req_addr = 64'(if_b.mem_req_addr); o_wb_valid = if_b.wb_valid;
            o_wb_data = 64'(if_b.wb_data); o_wb_rd = if_b.wb_rd; o_wb_fault = if_b.wb_fault;
        end else begin
            o_req_ready = if_c.req_ready; o_mem_req_valid = if_c.mem_req_valid;
            o_mem_req_addr = if_c.mem_req_addr; o_wb_valid = if_c.wb_valid;
            o_wb_data = if_c.wb_data; o_wb_rd = if_c.wb_rd; o_wb_fault = if_c.wb_fault;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int req_seen = 0;

    // Count memory request handshakes of the selected unit.
    always @(negedge clk) begin
        if (o_mem_req_valid && mem_req_ready) req_seen++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Present one request for a single clock; the unit must be idle.
    task automatic issue(input string tag, input int d, input logic [5:0] sel,
                         input logic [63:0] addr, input logic [4:0] rd);
        dut_sel = d;
        #1;
        check({tag, "_req_ready"}, 64'(o_req_ready), 64'd1);
        req_valid = 1'b1; req_sel = sel; req_addr = addr; req_rd = rd;
        step();
        req_valid = 1'b0;
    endtask

    // Wait for a beat request, check its address and return data one cycle later.
    task automatic serve(input string tag, input logic [63:0] exp_addr,
                         input logic [63:0] data, output int lat);
        lat = 0;
        while (!o_mem_req_valid && lat < 8) begin
            step();
            lat++;
        end
        check({tag, "_mreq_valid"}, 64'(o_mem_req_valid), 64'd1);
        check({tag, "_mreq_addr"}, o_mem_req_addr, exp_addr);
        step();
        mem_resp_valid = 1'b1; mem_resp_data = data;
        step();
        mem_resp_valid = 1'b0; mem_resp_data = 64'd0;
    endtask

    // Wait for the result, check it and complete the writeback handshake.
    task automatic collect(input string tag, input logic [63:0] exp_data,
                           input logic [4:0] exp_rd, input logic exp_fault, output int lat);
        lat = 0;
        while (!o_wb_valid && lat < 8) begin
            step();
            lat++;
        end
        check({tag, "_wb_valid"}, 64'(o_wb_valid), 64'd1);
        check({tag, "_wb_data"}, o_wb_data, exp_data);
        check({tag, "_wb_rd"}, 64'(o_wb_rd), 64'(exp_rd));
        check({tag, "_wb_fault"}, 64'(o_wb_fault), 64'(exp_fault));
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        check({tag, "_idle_ready"}, 64'(o_req_ready), 64'd1);
        check({tag, "_idle_wbv"}, 64'(o_wb_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no end expected end");
        $fatal(1, "bench timeout");
    end

    initial begin
        int lat, r0;
        reset = 1'b1; req_valid = 1'b0; req_sel = 6'd0; req_addr = 64'd0; req_rd = 5'd0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = 64'd0;
        wb_ready = 1'b0; dut_sel = 0;
        step(); step();
        reset = 1'b0;
        step();

        check("rst_req_ready", 64'(o_req_ready), 64'd1);
        check("rst_mreq_valid", 64'(o_mem_req_valid), 64'd0);
        check("rst_mreq_addr", o_mem_req_addr, 64'd0);
        check("rst_wb_valid", 64'(o_wb_valid), 64'd0);
        check("rst_wb_data", o_wb_data, 64'd0);
        check("rst_wb_rd", 64'(o_wb_rd), 64'd0);
        check("rst_wb_fault", 64'(o_wb_fault), 64'd0);

        // LB at offset 3, with the three-cycle latency checked.
        r0 = req_seen;
        issue("lb", 0, SEL_LB, 64'h1003, 5'd3);
        serve("lb", 64'h1000, 64'hA512_3456, lat);
        check("lb_mreq_lat", 64'(lat), 64'd0);
        collect("lb", 64'hFFFF_FFA5, 5'd3, 1'b0, lat);
        check("lb_wb_lat", 64'(lat), 64'd0);
        check("lb_nreq", 64'(req_seen - r0), 64'd1);

        // LHU at offset 2, then hold writeback off with a new request pending.
        issue("lhu", 0, SEL_LHU, 64'h2002, 5'd4);
        serve("lhu", 64'h2000, 64'h1234_ABCD, lat);
        req_valid = 1'b1; req_sel = SEL_LBU; req_addr = 64'h1001; req_rd = 5'd7;
        for (int i = 0; i < 3; i++) begin
            check("stall_wb_valid", 64'(o_wb_valid), 64'd1);
            check("stall_wb_data", o_wb_data, 64'h1234);
            check("stall_wb_rd", 64'(o_wb_rd), 64'd4);
            check("stall_wb_fault", 64'(o_wb_fault), 64'd0);
            check("stall_req_ready", 64'(o_req_ready), 64'd0);
            step();
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        check("stall_done_ready", 64'(o_req_ready), 64'd1);
        check("stall_done_mreq", 64'(o_mem_req_valid), 64'd0);
        step();
        req_valid = 1'b0;
        serve("lbu", 64'h1000, 64'hA512_3456, lat);
        check("lbu_mreq_lat", 64'(lat), 64'd0);
        collect("lbu", 64'h34, 5'd7, 1'b0, lat);

        // Misaligned LW split into two beats.
        r0 = req_seen;
        issue("lw_split", 0, SEL_LW, 64'h3001, 5'd5);
        serve("lw_b0", 64'h3000, 64'h4433_2211, lat);
        serve("lw_b1", 64'h3004, 64'h8877_6655, lat);
        collect("lw_split", 64'h5544_3322, 5'd5, 1'b0, lat);
        check("lw_split_nreq", 64'(req_seen - r0), 64'd2);

        // Split halfword whose second beat wraps to address 0.
        issue("lh_wrap", 0, SEL_LH, 64'hFFFF_FFFF, 5'd6);
        serve("lh_wrap_b0", 64'hFFFF_FFFC, 64'h1122_3344, lat);
        serve("lh_wrap_b1", 64'h0, 64'hAABB_CC80, lat);
        collect("lh_wrap", 64'hFFFF_8011, 5'd6, 1'b0, lat);

        // Unknown code and LD on a 32-bit unit both return the raw beat.
        issue("pass", 0, 6'b000000, 64'h5007, 5'd8);
        serve("pass", 64'h5004, 64'hCAFE_F00D, lat);
        collect("pass", 64'hCAFE_F00D, 5'd8, 1'b0, lat);
        issue("ld32", 0, SEL_LD, 64'h5002, 5'd10);
        serve("ld32", 64'h5000, 64'h8765_4321, lat);
        collect("ld32", 64'h8765_4321, 5'd10, 1'b0, lat);

        // Faulting unit: crossing halfword answers next cycle without memory.
        r0 = req_seen;
        issue("fault", 1, SEL_LH, 64'h4003, 5'd9);
        check("fault_mreq", 64'(o_mem_req_valid), 64'd0);
        collect("fault", 64'd0, 5'd9, 1'b1, lat);
        check("fault_lat", 64'(lat), 64'd0);
        check("fault_nreq", 64'(req_seen - r0), 64'd0);

        // Reset while waiting for the second beat; the late beat is dropped.
        issue("rst_mid", 0, SEL_LW, 64'h3001, 5'd12);
        serve("rst_mid_b0", 64'h3000, 64'h4433_2211, lat);
        step();
        reset = 1'b1;
        #1;
        check("rstmid_req_ready", 64'(o_req_ready), 64'd1);
        check("rstmid_mreq_valid", 64'(o_mem_req_valid), 64'd0);
        check("rstmid_mreq_addr", o_mem_req_addr, 64'd0);
        check("rstmid_wb_valid", 64'(o_wb_valid), 64'd0);
        check("rstmid_wb_data", o_wb_data, 64'd0);
        check("rstmid_wb_rd", 64'(o_wb_rd), 64'd0);
        check("rstmid_wb_fault", 64'(o_wb_fault), 64'd0);
        step();
        reset = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 64'h8877_6655;
        step();
        mem_resp_valid = 1'b0; mem_resp_data = 64'd0;
        for (int i = 0; i < 3; i++) begin
            check("rstmid_post_wbv", 64'(o_wb_valid), 64'd0);
            check("rstmid_post_ready", 64'(o_req_ready), 64'd1);
            check("rstmid_post_mreq", 64'(o_mem_req_valid), 64'd0);
            step();
        end

        // 64-bit unit: split LWU, then aligned LW and LD.
        issue("lwu64", 2, SEL_LWU, 64'h6, 5'd11);
        serve("lwu64_b0", 64'h0, 64'hDDCC_BBAA_0000_0000, lat);
        serve("lwu64_b1", 64'h8, 64'h0000_0000_0000_FF11, lat);
        collect("lwu64", 64'h0000_0000_FF11_DDCC, 5'd11, 1'b0, lat);
        issue("lw64", 2, SEL_LW, 64'h10, 5'd13);
        serve("lw64", 64'h10, 64'h0000_0000_8000_0001, lat);
        collect("lw64", 64'hFFFF_FFFF_8000_0001, 5'd13, 1'b0, lat);
        issue("ld64", 2, SEL_LD, 64'h18, 5'd14);
        serve("ld64", 64'h18, 64'h8877_6655_4433_2211, lat);
        collect("ld64", 64'h8877_6655_4433_2211, 5'd14, 1'b0, lat);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Sequential, parametrised successor to the writeback-stage load converter.
- Takes a load request (select code, byte address, rd), fetches one or two XLEN-wide memory beats, and extracts the addressed byte/half/word/dword with sign or zero extension.
- Returns the result to writeback through a valid/ready handshake.
- Sits between the MEM-stage data memory port and the WB register-file write mux.

Parameters:
- XLEN, 32, datapath and memory beat width; legal values 32 or 64.
- SPLIT_EN, 1, 1 = misaligned loads crossing a beat boundary are split into two beats; 0 = they raise wb_fault.
- RD_W, 5, destination register tag width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  load request present
- req_ready  out  1  unit idle, request accepted on req_valid&&req_ready
- req_sel  in  6  load select code (see Behaviour)
- req_addr  in  XLEN  byte address
- req_rd  in  RD_W  destination tag
- mem_req_valid  out  1  beat read request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  XLEN  beat-aligned address
- mem_resp_valid  in  1  read data valid, no backpressure
- mem_resp_data  in  XLEN  read data
- wb_valid  out  1  result valid
- wb_ready  in  1  writeback accepts result
- wb_data  out  XLEN  extended load value
- wb_rd  out  RD_W  destination tag
- wb_fault  out  1  misaligned-access fault (SPLIT_EN=0 only)

Behaviour:
- Reset: clk/reset are the only timing inputs; reset is asynchronous and active-high and forces state IDLE, req_ready=1, mem_req_valid=0, mem_req_addr=0, wb_valid=0, wb_data=0, wb_rd=0, wb_fault=0.
- Select codes (6 bit):
  - LB=001011, LH=001100, LW=001101, LBU=001110, LHU=001111; LWU=010001 and LD=010000 are valid only when XLEN=64.
  - Any other code (or LD/LWU at XLEN=32) is PASS: one beat at the aligned address, raw beat returned unmodified.
  - Sizes: B=1, H=2, W=4, D=8 bytes; PASS = XLEN/8 bytes at offset 0.
- Addressing:
  - BYTES=XLEN/8; off=req_addr[log2(BYTES)-1:0].
  - beat0 = req_addr & ~(BYTES-1); beat1 = beat0+BYTES, wrapping modulo 2^XLEN.
  - split = (off+size > BYTES).
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
  - IDLE: req_ready=1. On accept, latch sel, off, rd. If split && !SPLIT_EN, go to RESP with wb_fault=1, wb_data=0, and no memory access. Otherwise go to REQ0.
  - REQ0: mem_req_valid=1, addr=beat0. On mem_req_ready, go to WAIT0.
  - WAIT0: on mem_resp_valid, latch low beat. Go to REQ1 if split, else RESP.
  - REQ1/WAIT1: same handshake with beat1; latch high beat, then RESP.
  - RESP: wb_valid=1; wb_data, wb_rd and wb_fault are stable until wb_ready, then go to IDLE.
- Extraction: window = {high,low} >> (off*8); keep the low size*8 bits. LB/LH/LW (W only at XLEN=64) are sign-extended; LBU/LHU/LWU are zero-extended; LW at XLEN=32 and LD are full width. For non-split loads, high = 0.
- Latency, aligned load with mem_req_ready=1 and 1-cycle memory: accept at edge N, mem_req_valid in N+1, mem_resp_valid in N+2, wb_valid in N+3. A split load adds 2 cycles.
- Boundaries:
  - One outstanding load only; req_ready=0 outside IDLE.
  - mem_resp_valid outside WAIT0/WAIT1 is ignored.
  - The result is registered in RESP; wb_ready is irrelevant when wb_valid=0.
  - Reset in any state returns to IDLE immediately; a memory response arriving later is ignored.
  - A beat1 address wrapping past 2^XLEN-1 goes to 0.

Decomposition:
- Package load_pkg: select-code localparams, size-decode function, state enum encoding.
- Sub-module load_extract, purely combinational (sel, off, low, high -> data); unit-testable on its own, and it replaces the old converter at the WB mux.

Test Plan:
- XLEN=32: LB addr 0x1003, beat @0x1000 = 0xA5123456 -> one mem_req to 0x1000, wb_data=0xFFFFFFA5, wb_valid 3 cycles after accept.
- LHU addr 0x2002, beat = 0x1234ABCD -> wb_data=0x00001234, wb_fault=0.
- SPLIT_EN=1, LW addr 0x3001:
  - Beats 0x44332211 @0x3000 and 0x88776655 @0x3004.
  - Exactly two mem_reqs (0x3000, 0x3004) -> wb_data=0x55443322.
- SPLIT_EN=0, LH addr 0x4003 -> no mem_req_valid, wb_valid next cycle with wb_fault=1, wb_data=0.
- wb_ready held low 3 cycles in RESP -> wb_valid/wb_data/wb_rd stable, req_ready=0; a new request is accepted only after the wb_ready handshake.
- Reset pulsed in WAIT1, then mem_resp_valid arrives -> all outputs at reset values, req_ready=1, response ignored, no wb_valid. Then, at XLEN=64, LWU addr 0x6, beats 0xDDCCBBAA00000000 and 0x...FF11 -> wb_data=0x00000000FF11DDCC.
